// File: rtl/dump_pkg.sv
// Shared definitions for the run/dump controller: state encoding, word and index widths.
package dump_pkg;
    localparam int DUMP_DATA_W = 32;
    localparam int IDX_W       = 5;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_RF_RD,
        ST_RF_OUT,
        ST_MEM_RD,
        ST_MEM_OUT,
        ST_DONE
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/dump_out_reg.sv
// Output holding register: a loaded word stays put until the sink takes it.
module dump_out_reg
    import dump_pkg::*;
#(
    parameter int DATA_W = DUMP_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_kind,
    input  logic [IDX_W-1:0]  load_index,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic              kind,
    output logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            kind  <= 1'b0;
            index <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            kind  <= load_kind;
            index <= load_index;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/run_dump_ctrl.sv
// Counts RUN cycles until a zero instruction halts the core, then streams the
// register file followed by data memory out through a valid/ready port.
module run_dump_ctrl
    import dump_pkg::*;
#(
    parameter int DATA_W  = DUMP_DATA_W,
    parameter int NUM_RF  = 32,
    parameter int NUM_MEM = 32,
    parameter int TIMEOUT = 1000,
    parameter int DRAIN   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [IDX_W-1:0]  mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_kind,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       cycle_count,
    output logic              done,
    output logic              timeout
);

    localparam idx_t        LAST_RF    = idx_t'(NUM_RF - 1);
    localparam idx_t        LAST_MEM   = idx_t'(NUM_MEM - 1);
    localparam logic [31:0] CNT_LIMIT  = 32'(TIMEOUT - 1);
    localparam logic [31:0] DRAIN_LAST = 32'((DRAIN > 0) ? DRAIN - 1 : 0);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    state_t      state;
    idx_t        idx;
    logic [31:0] drain_cnt;
    logic        load;
    logic        load_kind;
    logic [DATA_W-1:0] load_data;

    // Read data for the address registered in an RD state is sampled at the end of that state.
    assign load      = (state == ST_RF_RD) || (state == ST_MEM_RD);
    assign load_kind = (state == ST_MEM_RD);
    assign load_data = load_kind ? mem_rdata : rf_rdata;

    dump_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_kind  (load_kind),
        .load_index (idx),
        .load_data  (load_data),
        .ready      (out_ready),
        .valid      (out_valid),
        .kind       (out_kind),
        .index      (out_index),
        .data       (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            idx         <= '0;
            drain_cnt   <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            rf_raddr    <= '0;
            mem_raddr   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    // A zero instruction is checked first so halt beats timeout.
                    if (instr == '0) begin
                        if (DRAIN == 0) begin
                            state    <= ST_RF_RD;
                            rf_raddr <= idx;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else if (cycle_count == CNT_LIMIT) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cycle_count <= sat_inc(cycle_count);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= ST_RF_RD;
                        rf_raddr <= idx;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end
                ST_RF_RD: begin
                    state    <= ST_RF_OUT;
                    rf_raddr <= '0;
                end
                ST_RF_OUT: begin
                    if (out_valid && out_ready) begin
                        if (idx == LAST_RF) begin
                            idx       <= '0;
                            state     <= ST_MEM_RD;
                            mem_raddr <= '0;
                        end else begin
                            idx      <= idx + 1'b1;
                            state    <= ST_RF_RD;
                            rf_raddr <= idx + 1'b1;
                        end
                    end
                end
                ST_MEM_RD: begin
                    state     <= ST_MEM_OUT;
                    mem_raddr <= '0;
                end
                ST_MEM_OUT: begin
                    if (out_valid && out_ready) begin
                        if (idx == LAST_MEM) begin
                            idx   <= '0;
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx       <= idx + 1'b1;
                            state     <= ST_MEM_RD;
                            mem_raddr <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Randomized scoreboard bench for run_dump_ctrl; a second instance with a drain delay checks dump start timing.
`timescale 1ns/1ps
module tb_run_dump_ctrl;
    import dump_pkg::*;

    localparam int DW      = DUMP_DATA_W;
    localparam int NRF     = 32;
    localparam int NMEM    = 32;
    localparam int TMO     = 1000;
    localparam int DRAIN_B = 5;

    typedef struct packed {
        logic          kind;
        idx_t          index;
        logic [DW-1:0] data;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [DW-1:0] instr = '0;
    idx_t          rf_raddr_a, mem_raddr_a, rf_raddr_b, mem_raddr_b;
    logic [DW-1:0] rf_rdata_a, mem_rdata_a, rf_rdata_b, mem_rdata_b;
    logic          out_valid_a, out_kind_a, done_a, tmo_a;
    logic          out_valid_b, out_kind_b, done_b, tmo_b;
    logic          out_ready_a = 1'b1;
    logic          out_ready_b = 1'b1;
    idx_t          out_index_a, out_index_b;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [31:0]   cc_a, cc_b;

    logic [DW-1:0] rf_mem  [NRF];
    logic [DW-1:0] mem_mem [NMEM];

    assign rf_rdata_a  = rf_mem[rf_raddr_a];
    assign mem_rdata_a = mem_mem[mem_raddr_a];
    assign rf_rdata_b  = rf_mem[rf_raddr_b];
    assign mem_rdata_b = mem_mem[mem_raddr_b];

    run_dump_ctrl #(.DATA_W(DW), .NUM_RF(NRF), .NUM_MEM(NMEM), .TIMEOUT(TMO), .DRAIN(0)) dut_a (
        .clk(clk), .rst(rst), .instr(instr),
        .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
        .mem_raddr(mem_raddr_a), .mem_rdata(mem_rdata_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_kind(out_kind_a),
        .out_index(out_index_a), .out_data(out_data_a),
        .cycle_count(cc_a), .done(done_a), .timeout(tmo_a)
    );

    run_dump_ctrl #(.DATA_W(DW), .NUM_RF(NRF), .NUM_MEM(NMEM), .TIMEOUT(TMO), .DRAIN(DRAIN_B)) dut_b (
        .clk(clk), .rst(rst), .instr(instr),
        .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
        .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_kind(out_kind_b),
        .out_index(out_index_b), .out_data(out_data_b),
        .cycle_count(cc_b), .done(done_b), .timeout(tmo_b)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    int    a_first = -1;
    int    b_first = -1;
    word_t b_first_word;
    word_t exp_q [$];
    int    exp_cnt;
    bit    exp_tmo;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready_a = 1'b1;
            1:       out_ready_a = ~out_ready_a;
            default: out_ready_a = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor for instance A: pops on every transfer, checks holding during stalls.
    initial begin
        word_t cur, held, e;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else if (out_valid_a) begin
                cur = '{out_kind_a, out_index_a, out_data_a};
                if (a_first < 0) a_first = cyc;
                if (stalled) check("hold_stable", 64'(cur), 64'(held));
                if (out_ready_a) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %0h want none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("dump_word", 64'(cur), 64'(e));
                    end
                    stalled = 1'b0;
                end else begin
                    held = cur;
                    stalled = 1'b1;
                end
            end else begin
                if (stalled) check("valid_dropped", 64'(out_valid_a), 64'(1));
                stalled = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && out_valid_b && b_first < 0) begin
            b_first = cyc;
            b_first_word = '{out_kind_b, out_index_b, out_data_b};
        end
    end

    // Reference: n busy cycles, then a halt; dump of every rf entry then every mem word.
    task automatic model(input int n);
        exp_q.delete();
        if (n >= TMO) begin
            exp_tmo = 1'b1;
            exp_cnt = TMO - 1;
        end else begin
            exp_tmo = 1'b0;
            exp_cnt = n;
            for (int i = 0; i < NRF; i++)  exp_q.push_back('{1'b0, idx_t'(i), rf_mem[i]});
            for (int i = 0; i < NMEM; i++) exp_q.push_back('{1'b1, idx_t'(i), mem_mem[i]});
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NRF; i++)  rf_mem[i] = $urandom();
        for (int i = 0; i < NMEM; i++) mem_mem[i] = $urandom();
    endtask

    task automatic run_case(input int n, input int mode, input bit do_abort);
        int halt_cyc;
        int k;
        word_t w0;
        logic [31:0] cc_hold;
        ready_mode = mode;
        rst = 1'b1;
        instr = $urandom();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              64'({cc_a, done_a, tmo_a, out_valid_a, out_kind_a, out_index_a, rf_raddr_a, mem_raddr_a}), 64'(0));
        check("reset_data", 64'(out_data_a), 64'(0));
        model(n);
        a_first = -1;
        b_first = -1;
        halt_cyc = -1;
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            instr = $urandom();
            if (instr == '0) instr = 1;
            if (i == TMO - 1) check("done_before_limit", 64'(done_a), 64'(0));
            @(posedge clk);
            #1;
        end
        if (n >= TMO) check("done_at_limit", 64'({done_a, tmo_a}), 64'(2'b11));
        instr = '0;
        halt_cyc = cyc;
        @(posedge clk);
        #1;
        k = 0;
        while (!(done_a && done_b) && k < 2000) begin
            if (do_abort && out_valid_a && !out_kind_a && out_index_a == idx_t'(9)) begin
                rst = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1;
                check("abort_valid", 64'({out_valid_a, out_valid_b}), 64'(0));
                return;
            end
            instr = $urandom();
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: got %0d cycles want done", k);
        end
        check("cycle_count_a", 64'(cc_a), 64'(exp_cnt));
        check("cycle_count_b", 64'(cc_b), 64'(exp_cnt));
        check("timeout_flag", 64'({tmo_a, tmo_b}), 64'({exp_tmo, exp_tmo}));
        check("words_left", 64'(exp_q.size()), 64'(0));
        if (exp_tmo) begin
            check("no_words_b", 64'(b_first), 64'(-1));
        end else begin
            w0 = '{1'b0, idx_t'(0), rf_mem[0]};
            check("first_latency_a", 64'(a_first - halt_cyc), 64'(2));
            check("first_latency_b", 64'(b_first - halt_cyc), 64'(DRAIN_B + 2));
            check("first_word_b", 64'(b_first_word), 64'(w0));
        end
        cc_hold = cc_a;
        repeat (3) begin
            instr = $urandom();
            @(posedge clk);
            #1;
        end
        check("done_frozen", 64'({cc_a, done_a, out_valid_a}), 64'({cc_hold, 1'b1, 1'b0}));
    endtask

    initial begin
        fill_random();
        run_case(7, 0, 1'b0);
        for (int i = 0; i < NRF; i++)  rf_mem[i] = DW'(i * 4);
        for (int i = 0; i < NMEM; i++) mem_mem[i] = DW'(i * 4);
        run_case(12, 1, 1'b0);
        fill_random();
        run_case(TMO, 0, 1'b0);
        run_case(TMO - 1, 2, 1'b0);
        fill_random();
        run_case(2, 2, 1'b0);
        fill_random();
        run_case(20, 0, 1'b1);
        run_case(20, 0, 1'b0);
        run_case(0, 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
